mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous memory between the tiny_cpu instruction
//   fetch (IF) and load/store (LS) units, running in the CPU clock domain.
//   Each unit uses a req/ready handshake. The arbiter serialises accesses,
//   drives the memory port, and returns read data per requester.
// PARAMETERS
//   ADDR_W   8   word address width
//   DATA_W   32  data width
//   MEM_LAT  1   memory read latency: cycles from mem_en to valid mem_rdata (legal 1..4)
// PORTS
//   CLK        in   1       system clock, rising edge
//   RST_N      in   1       asynchronous, active-low reset
//   if_req     in   1       fetch request (always a read)
//   if_addr    in   ADDR_W  fetch address
//   if_ready   out  1       one-cycle completion pulse for fetch
//   if_rdata   out  DATA_W  fetched word, valid when if_ready=1
//   ls_req     in   1       load/store request
//   ls_we      in   1       1 = store, 0 = load
//   ls_addr    in   ADDR_W  load/store address
//   ls_wdata   in   DATA_W  store data
//   ls_ready   out  1       one-cycle completion pulse for load/store
//   ls_rdata   out  DATA_W  load data, valid when ls_ready=1
//   mem_en     out  1       memory access strobe
//   mem_we     out  1       memory write enable
//   mem_addr   out  ADDR_W  memory address
//   mem_wdata  out  DATA_W  memory write data
//   mem_rdata  in   DATA_W  memory read data
// BEHAVIOUR
//   - Reset (RST_N=0, async): state=IDLE; all outputs 0; last_grant=IF.
//   - Handshake:
//     - requester holds req and its addr/we/wdata stable until its ready pulse;
//     - req may drop, or a new request be presented, in the cycle after ready.
//   - FSM:
//     - IDLE: no req -> stay. Any req -> latch winner, addr/we/wdata -> ISSUE.
//     - ISSUE (1 cycle): mem_en=1; mem_we=winner's we (IF always 0); mem_addr/wdata
//       = latched. Then read -> WAIT; write -> DONE.
//     - WAIT (MEM_LAT cycles, 2-bit down-counter): last cycle captures mem_rdata
//       into winner's rdata register -> DONE.
//     - DONE (1 cycle): winner's ready=1, other ready=0; req NOT sampled -> IDLE.
//   - Latency (req high in cycle 0): ISSUE = cycle 1; read ready = cycle MEM_LAT+2;
//     write ready = cycle 2. Max throughput: 1 read per MEM_LAT+3 cycles.
//   - All mem_* and *_ready outputs registered; mem_en/mem_we are 0 outside ISSUE.
//   - mem_addr/mem_wdata hold last values when idle.
//   - if_rdata/ls_rdata hold until that port's next read completes.
//     A store never changes ls_rdata.
//   - Simultaneous if_req & ls_req in IDLE: see CONFIGURATION; the loser waits,
//     its req still high, and is served on the next IDLE.
//   - Req dropped mid-transaction (protocol violation): the transaction still
//     completes and ready still pulses.
//   - Reset mid-transaction: access abandoned; no ready pulse; mem_en/mem_we=0 at once.
//   - Only one transaction is outstanding at any time; both ready outputs are
//     never 1 in the same cycle.
// CONFIGURATION
//   ARB_RR_EN undefined:
//     - fixed priority, LS beats IF; a pending data access always stalls the next fetch;
//     - last_grant register omitted.
//   ARB_RR_EN defined:
//     - round-robin on conflict: grant the requester not in last_grant;
//     - last_grant updated on every ISSUE;
//     - reset value IF, so the first conflict after reset goes to LS;
//     - a lone requester is always granted immediately.
// TESTING
//   1. Reset: RST_N=0 mid-WAIT
//      -> mem_en=0, both ready=0 same cycle; after release, IDLE with no ready pulse.
//   2. Single fetch, MEM_LAT=1: if_req=1, if_addr=8'h04, mem[4]=32'h00500093
//      -> mem_en cycle 1, addr 04; if_ready=1 and if_rdata=00500093 in cycle 3 only.
//   3. Store then load: ls_we=1, addr 8'h00, wdata 32'h2A
//      -> mem_we=1 cycle 1, ls_ready cycle 2.
//      Then load addr 8'h00 -> ls_rdata=32'h0000002A.
//   4. Conflict: if_req & ls_req same cycle.
//      -> LS served first, IF ready MEM_LAT+3 cycles after LS ready;
//      with ARB_RR_EN, a second conflict goes to IF.
//   5. Starvation check, ARB_RR_EN undefined: ls_req held high for 5 loads
//      -> no if_ready during them; IF served once ls_req drops.
//   6. MEM_LAT=4: single load
//      -> ls_ready exactly in cycle 6; mem_rdata sampled in the 4th WAIT cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous memory between fetch (IF) and load/store (LS).
// Optional feature: define ARB_RR_EN for round-robin conflict resolution (default: LS over IF).
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT - 1);

  state_t     state_q;
  state_t     state_d;
  logic       sel_ls_q;
  logic       we_q;
  logic [1:0] cnt_q;
  logic       grant_ls;
  logic       start;
  logic       last_wait;

`ifdef ARB_RR_EN
  // 1 = LS was the most recent grant; on a conflict the other side wins.
  logic last_grant_q;

  assign grant_ls = ls_req & (~if_req | ~last_grant_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_grant_q <= 1'b0;
    end else if (state_q == ISSUE) begin
      last_grant_q <= sel_ls_q;
    end
  end
`else
  assign grant_ls = ls_req;
`endif

  assign start     = (state_q == IDLE) & (if_req | ls_req);
  assign last_wait = (state_q == WAIT) & (cnt_q == 2'd0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req | ls_req) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control: winner, direction, wait counter and the registered strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sel_ls_q <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= 2'd0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      ls_ready <= 1'b0;
    end else begin
      if (start) begin
        sel_ls_q <= grant_ls;
        we_q     <= grant_ls & ls_we;
        cnt_q    <= WAIT_INIT;
      end else if ((state_q == WAIT) && (cnt_q != 2'd0)) begin
        cnt_q <= cnt_q - 2'd1;
      end
      mem_en   <= start;
      mem_we   <= start & grant_ls & ls_we;
      if_ready <= (state_d == DONE) & ~sel_ls_q;
      ls_ready <= (state_d == DONE) & sel_ls_q;
    end
  end

  // Data: address/write data latched at grant and held while idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (start) begin
      mem_addr <= grant_ls ? ls_addr : if_addr;
      if (grant_ls) begin
        mem_wdata <= ls_wdata;
      end
    end
  end

  // Read data captured in the final wait cycle, per requester.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      if_rdata <= '0;
      ls_rdata <= '0;
    end else if (last_wait) begin
      if (sel_ls_q) begin
        ls_rdata <= mem_rdata;
      end else begin
        if_rdata <= mem_rdata;
      end
    end
  end

endmodule
